udma_event_arb: RTL and testbench
=================================

Name: udma_event_arb

Overview:
- Round-robin arbiter that merges event requests from several uDMA peripherals onto the single 8-bit event channel of the uDMA control block (event_valid/event_data/event_ready).
- Each requester presents an 8-bit event ID with a valid/ready handshake.
- The winner is captured in a registered output stage, so the downstream comparator sees a clean, stable channel at one event per cycle.
- Sits between the peripheral event outputs and the uDMA control block.

Parameters:
- N_SRC, 4, number of requesting sources (>=1)
- SRC_W, derived: N_SRC>1 ? $clog2(N_SRC) : 1, width of the source index (localparam, not overridable)

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- src_en_i  in  N_SRC  per-source enable mask; a 0 bit makes that source ineligible
- evt_valid_i  in  N_SRC  per-source event request
- evt_data_i  in  8*N_SRC  per-source event ID; source k at bits [8k+7:8k]
- evt_ready_o  out  N_SRC  per-source accept, at most one bit high per cycle
- event_valid_o  out  1  merged event valid, registered
- event_data_o  out  8  merged event ID, registered
- event_src_o  out  SRC_W  index of the source that produced event_data_o, registered
- event_ready_i  in  1  downstream accept

Behaviour:
- Reset (async, rstn_i low):
  - event_valid_o=0, event_data_o=0, event_src_o=0.
  - Round-robin pointer r_ptr=0.
  - evt_ready_o=0 while in reset.
- Output-stage handshake:
  - A transfer completes downstream when event_valid_o & event_ready_i.
  - While event_valid_o=1 and event_ready_i=0, event_valid_o, event_data_o and event_src_o hold stable.
- Load enable: s_load = ~event_valid_o | event_ready_i. Arbitration occurs only in cycles where s_load=1.
- Eligibility: s_elig = evt_valid_i & src_en_i.
- Grant:
  - When s_load=1 and s_elig!=0, the winner g is the first set bit of s_elig searching upward from index r_ptr, wrapping from N_SRC-1 to 0.
  - evt_ready_o[g]=1 combinationally in that cycle; all other ready bits are 0.
  - On the next edge: event_valid_o<=1, event_data_o<=evt_data_i[g], event_src_o<=g, r_ptr<=(g==N_SRC-1)?0:g+1.
- Idle load: when s_load=1 and s_elig==0, event_valid_o<=0 on the next edge. Data, src and r_ptr hold.
- Stall: when s_load=0, all evt_ready_o=0 and r_ptr holds.
- Latency and throughput:
  - Request accepted in cycle t appears on event_valid_o in cycle t+1.
  - Sustained throughput is one event per cycle when event_ready_i stays 1.
- Combinational path: evt_ready_o depends combinationally on event_ready_i, evt_valid_i and src_en_i. There is no combinational path from evt_data_i to any output.
- Fairness: a source held valid and enabled is granted within N_SRC consecutive grants.
- Source-side handshake: a source drops or changes its request only after seeing its evt_ready_o bit high. The arbiter does not latch requests that are not granted.
- Mask changes:
  - A src_en_i change takes effect in the same cycle's arbitration.
  - An event already in the output register is unaffected and is still delivered.
- N_SRC=1: r_ptr and event_src_o are constant 0; the block behaves as a one-deep pipeline register gated by src_en_i[0].
- Simultaneous downstream accept and new grant in the same cycle: the old event retires and the new one loads, with no bubble.
- Reset asserted mid-transfer: the registered event is discarded (event_valid_o=0 immediately) and r_ptr returns to 0.

Test Plan:
1. Reset, then source 2 valid with data 0x5A, all enabled, event_ready_i=1 -> evt_ready_o=4'b0100 in cycle t; cycle t+1: event_valid_o=1, event_data_o=0x5A, event_src_o=2; r_ptr=3.
2. All four sources continuously valid with IDs 0x10,0x11,0x12,0x13, event_ready_i=1 -> back-to-back outputs 0x10,0x11,0x12,0x13,0x10 with src 0,1,2,3,0 and no bubbles.
3. Output holds 0x21 and event_ready_i=0 for 5 cycles while sources 0 and 1 are valid -> evt_ready_o=0 throughout; outputs stable at 0x21; on release, the next event issues the following cycle from source r_ptr.
4. src_en_i=4'b1101 with all sources valid, continuous ready -> source 1 is never granted; grant order 0,2,3,0.
5. Grant source 3 (r_ptr wraps to 0), then only sources 3 and 0 valid -> next grant is source 0, then source 3.
6. rstn_i pulsed low while event_valid_o=1 with data 0x7E -> event_valid_o=0 asynchronously; after release, the first grant searches from index 0.

Source files
------------

// File: rtl/udma_event_arb.sv
// udma_event_arb: round-robin merge of per-peripheral event requests onto the
// single registered uDMA event channel (valid/ready, 8-bit event ID).
module udma_event_arb #(
  parameter  int N_SRC = 4,
  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [N_SRC-1:0]   src_en_i,
  input  logic [N_SRC-1:0]   evt_valid_i,
  input  logic [8*N_SRC-1:0] evt_data_i,
  output logic [N_SRC-1:0]   evt_ready_o,
  output logic               event_valid_o,
  output logic [7:0]         event_data_o,
  output logic [SRC_W-1:0]   event_src_o,
  input  logic               event_ready_i
);

  logic               event_valid_q, event_valid_d;
  logic [7:0]         event_data_q, event_data_d;
  logic [SRC_W-1:0]   event_src_q, event_src_d;
  logic [SRC_W-1:0]   r_ptr_q, r_ptr_d;

  logic               s_load;
  logic [N_SRC-1:0]   s_elig;
  logic               gnt_found;
  logic [SRC_W-1:0]   gnt_idx;

  assign s_load = ~event_valid_q | event_ready_i;
  assign s_elig = evt_valid_i & src_en_i;

  // Round-robin search: first eligible source at or above r_ptr, wrapping.
  always_comb begin
    int cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int i = 0; i < N_SRC; i++) begin
      cand = int'(r_ptr_q) + i;
      if (cand >= N_SRC) cand = cand - N_SRC;
      if (!gnt_found && s_elig[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = SRC_W'(cand);
      end
    end
  end

  // Accept strobe to the winner; suppressed while stalled and while in reset.
  always_comb begin
    evt_ready_o = '0;
    if (rstn_i && s_load && gnt_found) evt_ready_o[gnt_idx] = 1'b1;
  end

  // Next output-stage contents: load winner, go idle, or hold on stall.
  always_comb begin
    event_valid_d = event_valid_q;
    event_data_d  = event_data_q;
    event_src_d   = event_src_q;
    r_ptr_d       = r_ptr_q;
    if (s_load) begin
      if (gnt_found) begin
        event_valid_d = 1'b1;
        event_data_d  = evt_data_i[8*int'(gnt_idx) +: 8];
        event_src_d   = gnt_idx;
        r_ptr_d       = (int'(gnt_idx) == N_SRC-1) ? '0 : gnt_idx + 1'b1;
      end else begin
        event_valid_d = 1'b0;
      end
    end
  end

  // Output register and round-robin pointer; reset discards any pending event.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      event_valid_q <= 1'b0;
      event_data_q  <= '0;
      event_src_q   <= '0;
      r_ptr_q       <= '0;
    end else begin
      event_valid_q <= event_valid_d;
      event_data_q  <= event_data_d;
      event_src_q   <= event_src_d;
      r_ptr_q       <= r_ptr_d;
    end
  end

  assign event_valid_o = event_valid_q;
  assign event_data_o  = event_data_q;
  assign event_src_o   = event_src_q;

endmodule

// File: tb/tb_udma_event_arb.sv
// Directed self-checking bench for udma_event_arb (N_SRC=4).
module tb_udma_event_arb;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic [3:0]  src_en_i = 4'hF;
  logic [3:0]  evt_valid_i = '0;
  logic [31:0] evt_data_i = '0;
  logic [3:0]  evt_ready_o;
  logic        event_valid_o;
  logic [7:0]  event_data_o;
  logic [1:0]  event_src_o;
  logic        event_ready_i = 1'b1;

  int n_chk = 0;
  int n_pass = 0;

  udma_event_arb #(.N_SRC(4)) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .src_en_i      (src_en_i),
    .evt_valid_i   (evt_valid_i),
    .evt_data_i    (evt_data_i),
    .evt_ready_o   (evt_ready_o),
    .event_valid_o (event_valid_o),
    .event_data_o  (event_data_o),
    .event_src_o   (event_src_o),
    .event_ready_i (event_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_data(input int k, input logic [7:0] v);
    evt_data_i[8*k +: 8] = v;
  endtask

  // Reset with all requests idle; release away from the clock edge.
  task automatic do_reset();
    evt_valid_i   = '0;
    src_en_i      = 4'hF;
    event_ready_i = 1'b1;
    rstn_i        = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    rstn_i = 1'b1;
  endtask

  initial begin
    // Reset state, ready suppressed in reset even with a request present.
    evt_valid_i = 4'b0001;
    #2;
    chk("rst_ready", evt_ready_o, 4'b0000);
    chk("rst_valid", event_valid_o, 0);
    chk("rst_data", event_data_o, 0);
    chk("rst_src", event_src_o, 0);

    // 1: single request from source 2
    do_reset();
    set_data(2, 8'h5A);
    evt_valid_i = 4'b0100;
    #1;
    chk("t1_ready", evt_ready_o, 4'b0100);
    step();
    evt_valid_i = 4'b0000;
    chk("t1_valid", event_valid_o, 1);
    chk("t1_data", event_data_o, 8'h5A);
    chk("t1_src", event_src_o, 2);
    step();
    chk("t1_idle_valid", event_valid_o, 0);
    chk("t1_idle_data", event_data_o, 8'h5A);
    // r_ptr is 3: with sources 0 and 3 valid, source 3 wins
    evt_valid_i = 4'b1001;
    #1;
    chk("t1_rptr3", evt_ready_o, 4'b1000);

    // 2: all sources valid, back-to-back rotation
    do_reset();
    for (int k = 0; k < 4; k++) set_data(k, 8'h10 + 8'(k));
    evt_valid_i = 4'b1111;
    #1;
    chk("t2_ready0", evt_ready_o, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_valid", event_valid_o, 1);
      chk("t2_data", event_data_o, 8'h10 + 8'(i % 4));
      chk("t2_src", event_src_o, i % 4);
      chk("t2_ready", evt_ready_o, 4'b0001 << ((i + 1) % 4));
    end
    evt_valid_i = '0;

    // 3: downstream stall holds the output and blocks grants
    do_reset();
    event_ready_i = 1'b0;
    set_data(0, 8'h21);
    evt_valid_i = 4'b0001;
    #1;
    chk("t3_load_ready", evt_ready_o, 4'b0001);
    step();
    set_data(0, 8'h30);
    set_data(1, 8'h31);
    evt_valid_i = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_stall_ready", evt_ready_o, 4'b0000);
      chk("t3_stall_valid", event_valid_o, 1);
      chk("t3_stall_data", event_data_o, 8'h21);
      step();
    end
    event_ready_i = 1'b1;
    #1;
    chk("t3_rel_ready", evt_ready_o, 4'b0010);
    step();
    chk("t3_rel_data", event_data_o, 8'h31);
    chk("t3_rel_src", event_src_o, 1);
    chk("t3_next_ready", evt_ready_o, 4'b0001);
    step();
    chk("t3_next_data", event_data_o, 8'h30);
    chk("t3_next_src", event_src_o, 0);
    evt_valid_i = '0;

    // 4: source 1 masked off
    do_reset();
    for (int k = 0; k < 4; k++) set_data(k, 8'h80 + 8'(k));
    src_en_i = 4'b1101;
    evt_valid_i = 4'b1111;
    begin
      logic [1:0] exp_src [4];
      exp_src = '{2'd0, 2'd2, 2'd3, 2'd0};
      for (int i = 0; i < 4; i++) begin
        #1;
        chk("t4_no_src1", evt_ready_o[1], 0);
        step();
        chk("t4_src", event_src_o, exp_src[i]);
        chk("t4_data", event_data_o, 8'h80 + 8'(exp_src[i]));
      end
    end
    evt_valid_i = '0;

    // 5: wrap from source 3 back to 0
    do_reset();
    set_data(0, 8'h40);
    set_data(3, 8'h43);
    evt_valid_i = 4'b1000;
    #1;
    chk("t5_ready3", evt_ready_o, 4'b1000);
    step();
    chk("t5_src3", event_src_o, 3);
    evt_valid_i = 4'b1001;
    #1;
    chk("t5_ready0", evt_ready_o, 4'b0001);
    step();
    chk("t5_src0", event_src_o, 0);
    chk("t5_data0", event_data_o, 8'h40);
    chk("t5_ready3b", evt_ready_o, 4'b1000);
    step();
    chk("t5_src3b", event_src_o, 3);
    chk("t5_data3b", event_data_o, 8'h43);
    evt_valid_i = '0;

    // 6: asynchronous reset mid-transfer
    do_reset();
    event_ready_i = 1'b0;
    set_data(1, 8'h7E);
    evt_valid_i = 4'b0010;
    step();
    chk("t6_pre_data", event_data_o, 8'h7E);
    evt_valid_i = '0;
    #2;
    rstn_i = 1'b0;
    #1;
    chk("t6_async_valid", event_valid_o, 0);
    chk("t6_async_data", event_data_o, 0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    event_ready_i = 1'b1;
    set_data(1, 8'h61);
    set_data(2, 8'h62);
    evt_valid_i = 4'b0110;
    #1;
    chk("t6_ptr0_ready", evt_ready_o, 4'b0010);
    step();
    chk("t6_src", event_src_o, 1);
    chk("t6_data", event_data_o, 8'h61);
    evt_valid_i = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
